// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates two writeback requesters (ALU, load) onto a single
// register-file write port with a one-cycle registered write, x0 write suppression,
// and a saturating stall counter.
// Build option: define WB_ARB_RR_EN for round-robin when both requesters are valid;
// left undefined, requester 0 has fixed priority.
`timescale 1ns / 1ps
module regfile_wb_arbiter #(
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              req0_valid,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_data,
  output logic              req1_ready,
  output logic              r_we,
  output logic [AWIDTH-1:0] r_addr_rd,
  output logic [DWIDTH-1:0] r_data_rd,
  output logic              last_grant,
  output logic [15:0]       stall_cnt
);

  typedef enum logic {StLg0 = 1'b0, StLg1 = 1'b1} lg_state_e;

  lg_state_e         state_q, state_d;
  logic              gnt0, gnt1;
  logic              stall;
  logic [AWIDTH-1:0] addr_sel;
  logic [DWIDTH-1:0] data_sel;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [15:0]       stall_q, stall_d;

  // Last-grant state register; reset to LG1 so the first contention goes to requester 0.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      state_q <= StLg1;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows whichever requester is granted; holds when nobody transfers.
  always_comb begin
    state_d = state_q;
    if (gnt0) begin
      state_d = StLg0;
    end else if (gnt1) begin
      state_d = StLg1;
    end
  end

  // Grant decode; readies are forced low while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!r_rst) begin
      if (req0_valid && !req1_valid) begin
        gnt0 = 1'b1;
      end else if (!req0_valid && req1_valid) begin
        gnt1 = 1'b1;
      end else if (req0_valid && req1_valid) begin
`ifdef WB_ARB_RR_EN
        if (state_q == StLg0) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
`else
        gnt0 = 1'b1;
`endif
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign last_grant = (state_q == StLg1);

  // Write-port next state: x0 writes are accepted but never reach the register file.
  always_comb begin
    addr_sel = req0_addr;
    data_sel = req0_data;
    if (gnt1) begin
      addr_sel = req1_addr;
      data_sel = req1_data;
    end
    we_d   = (gnt0 || gnt1) && (addr_sel != '0);
    addr_d = we_d ? addr_sel : addr_q;
    data_d = we_d ? data_sel : data_q;
  end

  // Stall counter next state: any valid requester left waiting costs one cycle.
  always_comb begin
    stall   = (req0_valid && !gnt0) || (req1_valid && !gnt1);
    stall_d = stall_q;
    if (stall && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Registered write port and stall counter; reset also drops a pending write.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      stall_q <= 16'd0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      stall_q <= stall_d;
    end
  end

  assign r_we      = we_q;
  assign r_addr_rd = addr_q;
  assign r_data_rd = data_q;
  assign stall_cnt = stall_q;

endmodule
